// File: rtl/const_cfg_bank.sv
// Shift-loaded constant bank: serial config goes into a shadow register and is
// committed atomically to the registered outputs, with length checking.
module const_cfg_bank #(
  parameter int unsigned       WIDTH       = 8,
  parameter logic [WIDTH-1:0]  RESET_VAL   = '0,
  parameter int unsigned       CHECK_COUNT = 1
) (
  input  logic             prog_clk,
  input  logic             pReset,
  input  logic             shift_en,
  input  logic             ccff_head,
  input  logic             commit,
  output logic             ccff_tail,
  output logic [WIDTH-1:0] const_out,
  output logic             cfg_valid,
  output logic             cfg_err
);

  localparam int unsigned CW = $clog2(WIDTH + 2);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    LOADING = 2'd1,
    ACTIVE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shadow;
  logic [WIDTH-1:0] r_active;
  logic [CW-1:0]    r_count;
  logic             r_valid;
  logic             r_err;
  logic             w_count_ok;

  // Exact length required in checked mode; any non-empty load otherwise.
  assign w_count_ok = (CHECK_COUNT != 0) ? (r_count == CW'(WIDTH))
                                         : (r_count != CW'(0));

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      r_state  <= EMPTY;
      r_shadow <= '0;
      r_active <= RESET_VAL;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (shift_en) begin
        r_shadow <= {r_shadow[WIDTH-2:0], ccff_head};
        r_err    <= commit;
        if (r_state == LOADING) begin
          if (r_count != CW'(WIDTH + 1))
            r_count <= r_count + CW'(1);
        end else begin
          r_count <= CW'(1);
          r_state <= LOADING;
        end
      end else if (commit && (r_state == LOADING)) begin
        r_count <= '0;
        if (w_count_ok) begin
          r_active <= r_shadow;
          r_valid  <= 1'b1;
          r_state  <= ACTIVE;
        end else begin
          r_err   <= 1'b1;
          r_state <= r_valid ? ACTIVE : EMPTY;
        end
      end
    end
  end

  assign ccff_tail = r_shadow[WIDTH-1];
  assign const_out = r_active;
  assign cfg_valid = r_valid;
  assign cfg_err   = r_err;

endmodule

// File: tb/tb_const_cfg_bank.sv
// Directed bench for const_cfg_bank: WIDTH=4, RESET_VAL=1010, checked and
// unchecked commit modes driven from the same stimulus.
module tb_const_cfg_bank;

  logic       prog_clk = 1'b0;
  logic       pReset = 1'b0;
  logic       shift_en = 1'b0;
  logic       ccff_head = 1'b0;
  logic       commit = 1'b0;
  logic       ccff_tail, ccff_tail0;
  logic [3:0] const_out, const_out0;
  logic       cfg_valid, cfg_valid0;
  logic       cfg_err, cfg_err0;

  int total = 0;
  int bad   = 0;

  always #5 prog_clk = ~prog_clk;

  const_cfg_bank #(.WIDTH(4), .RESET_VAL(4'b1010), .CHECK_COUNT(1)) dut (
    .prog_clk(prog_clk), .pReset(pReset), .shift_en(shift_en),
    .ccff_head(ccff_head), .commit(commit), .ccff_tail(ccff_tail),
    .const_out(const_out), .cfg_valid(cfg_valid), .cfg_err(cfg_err)
  );

  const_cfg_bank #(.WIDTH(4), .RESET_VAL(4'b1010), .CHECK_COUNT(0)) dut0 (
    .prog_clk(prog_clk), .pReset(pReset), .shift_en(shift_en),
    .ccff_head(ccff_head), .commit(commit), .ccff_tail(ccff_tail0),
    .const_out(const_out0), .cfg_valid(cfg_valid0), .cfg_err(cfg_err0)
  );

  task automatic cyc();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic shift_bit(input logic b);
    shift_en  = 1'b1;
    ccff_head = b;
    cyc();
    shift_en  = 1'b0;
    ccff_head = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    cyc();
    commit = 1'b0;
  endtask

  task automatic pulse_reset();
    #2 pReset = 1'b1;
    #2;
    cyc();
    pReset = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0] obs;
    #3 pReset = 1'b1;
    #1;
    obs = {const_out, cfg_valid, cfg_err, ccff_tail};
    total++;
    if (obs !== 7'b1010_000) begin
      bad++; $display("FAIL reset_async out/valid/err/tail got=%b exp=%b", obs, 7'b1010_000);
    end
    // Inputs must be ignored while reset is held.
    shift_en = 1'b1; ccff_head = 1'b1; commit = 1'b1;
    cyc(); cyc(); cyc(); cyc(); cyc();
    obs = {const_out, cfg_valid, cfg_err, ccff_tail};
    total++;
    if (obs !== 7'b1010_000) begin
      bad++; $display("FAIL reset_hold_ignore got=%b exp=%b", obs, 7'b1010_000);
    end
    shift_en = 1'b0; ccff_head = 1'b0; commit = 1'b0;
    pReset = 1'b0;
    cyc();
  endtask

  task automatic test_full_load();
    logic [3:0] pat;
    pat = 4'b1100;
    for (int i = 3; i >= 0; i--) begin
      shift_bit(pat[i]);
      total++;
      if ({const_out, cfg_valid} !== 5'b1010_0) begin
        bad++; $display("FAIL full_load_hold step%0d got=%b exp=%b", 3 - i, {const_out, cfg_valid}, 5'b1010_0);
      end
    end
    total++;
    if (ccff_tail !== 1'b1) begin
      bad++; $display("FAIL full_load_tail got=%b exp=1", ccff_tail);
    end
    do_commit();
    total++;
    if ({const_out, cfg_valid, cfg_err} !== 6'b1100_10) begin
      bad++; $display("FAIL full_load_commit got=%b exp=%b", {const_out, cfg_valid, cfg_err}, 6'b1100_10);
    end
  endtask

  task automatic test_short_load();
    shift_bit(1'b0); shift_bit(1'b1); shift_bit(1'b1);
    total++;
    if ({const_out, cfg_valid} !== 5'b1100_1) begin
      bad++; $display("FAIL short_load_hold got=%b exp=%b", {const_out, cfg_valid}, 5'b1100_1);
    end
    do_commit();
    total++;
    if ({const_out, cfg_valid, cfg_err} !== 6'b1100_11) begin
      bad++; $display("FAIL short_load_err got=%b exp=%b", {const_out, cfg_valid, cfg_err}, 6'b1100_11);
    end
    cyc();
    total++;
    if (cfg_err !== 1'b0) begin
      bad++; $display("FAIL short_load_err_width got=%b exp=0", cfg_err);
    end
    do_commit();
    total++;
    if ({const_out, cfg_valid, cfg_err} !== 6'b1100_10) begin
      bad++; $display("FAIL short_load_recommit got=%b exp=%b", {const_out, cfg_valid, cfg_err}, 6'b1100_10);
    end
  endtask

  task automatic test_overshift();
    logic [4:0] seq;
    seq = 5'b10000;
    pulse_reset();
    for (int i = 4; i >= 0; i--) begin
      shift_bit(seq[i]);
      if (i == 1) begin
        total++;
        if (ccff_tail !== 1'b1) begin
          bad++; $display("FAIL overshift_tail4 got=%b exp=1", ccff_tail);
        end
      end
    end
    total++;
    if ({ccff_tail, ccff_tail0} !== 2'b00) begin
      bad++; $display("FAIL overshift_tail5 got=%b exp=00", {ccff_tail, ccff_tail0});
    end
    do_commit();
    total++;
    if ({const_out, cfg_valid, cfg_err} !== 6'b1010_01) begin
      bad++; $display("FAIL overshift_checked got=%b exp=%b", {const_out, cfg_valid, cfg_err}, 6'b1010_01);
    end
    total++;
    if ({const_out0, cfg_valid0, cfg_err0} !== 6'b0000_10) begin
      bad++; $display("FAIL overshift_unchecked got=%b exp=%b", {const_out0, cfg_valid0, cfg_err0}, 6'b0000_10);
    end
  endtask

  task automatic test_simultaneous();
    shift_bit(1'b1); shift_bit(1'b0); shift_bit(1'b1);
    shift_en = 1'b1; ccff_head = 1'b1; commit = 1'b1;
    cyc();
    shift_en = 1'b0; ccff_head = 1'b0; commit = 1'b0;
    total++;
    if ({const_out, cfg_valid, cfg_err, ccff_tail} !== 7'b1010_011) begin
      bad++; $display("FAIL simul_err got=%b exp=%b", {const_out, cfg_valid, cfg_err, ccff_tail}, 7'b1010_011);
    end
    do_commit();
    total++;
    if ({const_out, cfg_valid, cfg_err} !== 6'b1011_10) begin
      bad++; $display("FAIL simul_then_commit got=%b exp=%b", {const_out, cfg_valid, cfg_err}, 6'b1011_10);
    end
  endtask

  task automatic test_reset_mid_load();
    shift_bit(1'b1); shift_bit(1'b1); shift_bit(1'b0); shift_bit(1'b0);
    do_commit();
    total++;
    if ({const_out, cfg_valid} !== 5'b1100_1) begin
      bad++; $display("FAIL midrst_preload got=%b exp=%b", {const_out, cfg_valid}, 5'b1100_1);
    end
    shift_bit(1'b1); shift_bit(1'b0);
    #3 pReset = 1'b1;
    #1;
    total++;
    if ({const_out, cfg_valid, cfg_err, ccff_tail} !== 7'b1010_000) begin
      bad++; $display("FAIL midrst_async got=%b exp=%b", {const_out, cfg_valid, cfg_err, ccff_tail}, 7'b1010_000);
    end
    cyc();
    pReset = 1'b0;
    shift_bit(1'b0); shift_bit(1'b1); shift_bit(1'b1); shift_bit(1'b0);
    do_commit();
    total++;
    if ({const_out, cfg_valid, cfg_err} !== 6'b0110_10) begin
      bad++; $display("FAIL midrst_reload got=%b exp=%b", {const_out, cfg_valid, cfg_err}, 6'b0110_10);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc();
    test_reset();
    test_full_load();
    test_short_load();
    test_overshift();
    test_simultaneous();
    test_reset_mid_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/const_cfg_bank.md
CONST_CFG_BANK -- requirements
Module: const_cfg_bank

Interface
- REQ-001 SHALL have parameter WIDTH, default 8, meaning the number of constant outputs; legal range 2..64.
- REQ-002 SHALL have parameter RESET_VAL, WIDTH bits, default all-0, meaning the value driven on const_out while no configuration is committed.
- REQ-003 SHALL have parameter CHECK_COUNT, default 1, meaning: 1 = commit accepted only after exactly WIDTH shifts; 0 = commit accepted after at least 1 shift.
- REQ-004 SHALL have port prog_clk, input, 1 bit: the single clock; all state updates on its rising edge.
- REQ-005 SHALL have port pReset, input, 1 bit: asynchronous, active-high reset.
- REQ-006 SHALL have port shift_en, input, 1 bit: shift one configuration bit this cycle.
- REQ-007 SHALL have port ccff_head, input, 1 bit: serial configuration data in.
- REQ-008 SHALL have port commit, input, 1 bit: single-cycle request to transfer the shadow register to the outputs.
- REQ-009 SHALL have port ccff_tail, output, 1 bit: serial data out, equal to shadow[WIDTH-1], for chaining.
- REQ-010 SHALL have port const_out, output, WIDTH bits: registered constant outputs, const_out[i] = active[i].
- REQ-011 SHALL have port cfg_valid, output, 1 bit: high while a committed configuration drives const_out.
- REQ-012 SHALL have port cfg_err, output, 1 bit: one-cycle pulse on a rejected commit.

Function
- REQ-013 Shift SHALL behave as follows: on shift_en, shadow[0] <= ccff_head and shadow[i] <= shadow[i-1]; after WIDTH shifts, the first bit shifted in sits at shadow[WIDTH-1].
- REQ-014 Shift counter SHALL count shifts since the last commit or reset, saturating at WIDTH+1 (overshift marker); it clears on any commit, accepted or rejected.
- REQ-015 The FSM SHALL have states EMPTY (no config), LOADING (shifts since last commit), ACTIVE (config committed).
- REQ-016 EMPTY or ACTIVE with shift_en SHALL go to LOADING, with counter = 1 after that edge.
- REQ-017 LOADING with commit=1, shift_en=0 and count condition met SHALL go to ACTIVE, with active <= shadow and cfg_valid <= 1; const_out SHALL change exactly 1 cycle after the commit edge.
- REQ-018 Count condition SHALL be: count == WIDTH when CHECK_COUNT=1; count >= 1 (overshift included) when CHECK_COUNT=0.
- REQ-019 LOADING with commit=1, shift_en=0 and count condition not met SHALL pulse cfg_err for 1 cycle, leave active unchanged, return to ACTIVE if cfg_valid=1 else EMPTY, and keep shadow unchanged.
- REQ-020 commit and shift_en high in the same cycle SHALL perform the shift, ignore the commit, pulse cfg_err, and remain in or enter LOADING.
- REQ-021 commit in EMPTY or ACTIVE (no shift since last commit) SHALL be ignored, with no cfg_err.
- REQ-022 During LOADING, const_out and cfg_valid SHALL hold their previous values (glitch-free reconfiguration).
- REQ-023 ccff_tail SHALL be registered and valid regardless of FSM state; shifting beyond WIDTH SHALL pass data through unchanged.

Reset
- REQ-024 pReset high SHALL immediately, without waiting for a clock edge, force state=EMPTY, shadow=0, counter=0, active=RESET_VAL, cfg_valid=0, cfg_err=0, ccff_tail=0.
- REQ-025 pReset asserted mid-load SHALL discard the partial load; after release, the first shift_en edge SHALL start a fresh load.
- REQ-026 Inputs SHALL be ignored while pReset is high.

Verification (WIDTH=4, RESET_VAL=4'b1010 written bit3..bit0, CHECK_COUNT=1 unless stated)
- REQ-027 Reset: assert pReset asynchronously between edges -> const_out=1010, cfg_valid=0, cfg_err=0, ccff_tail=0 immediately.
- REQ-028 Full load: shift 1,1,0,0 then commit -> next cycle const_out=1100, cfg_valid=1; const_out stays 1010 during the shifts.
- REQ-029 Short load: 3 shifts then commit -> cfg_err pulses for 1 cycle, const_out unchanged, state back to EMPTY or ACTIVE; a further commit is ignored.
- REQ-030 Overshift: 5 shifts (1,0,0,0,0) -> ccff_tail=1 after the 4th shift edge and 0 after the 5th; commit -> cfg_err with CHECK_COUNT=1; accepted with const_out=0000 when CHECK_COUNT=0.
- REQ-031 Simultaneous events: commit and shift_en in the same cycle at count=3 -> shift occurs, count=4, cfg_err pulses; a subsequent lone commit is accepted.
- REQ-032 Reset mid-load: from ACTIVE=1100, 2 shifts then pReset -> const_out=1010 and cfg_valid=0 immediately; after release, 4 shifts plus commit load correctly.
